// File: rtl/qa_rcc_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding,
// 50 MHz default timing constants and a small helper for sizing counters.
// The optional auto-repeat feature is controlled by QA_KEY_AUTOREPEAT_EN.
package qa_rcc_pkg;

    // Debounce FSM states, also exported on the debug state port
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } key_state_t;

    // Default timing at 50 MHz: 20 ms debounce, 500 ms first repeat, 100 ms repeat
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Largest of three timing values, used to size the shared counter width
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/qa_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 on the asynchronous active-high reset.
module qa_sync2 (
    input  logic sysClk,
    input  logic sysReset,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the raw input, then re-register to resolve metastability
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qa_key_debounce.sv
// Debounces a raw mechanical key into a clean level plus one-cycle press
// and release pulses. Defining QA_KEY_AUTOREPEAT_EN adds auto-repeat press
// pulses while the key stays held; without it keyPress fires once per press.
//
// Handshake note: there is no valid/ready flow here; keyPress and keyRelease
// are single-cycle strobes that are never high together or back to back.
import qa_rcc_pkg::*;

module qa_key_debounce #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       sysClk,
    input  logic       sysReset,
    input  logic       keyIn,
    output logic       keyLevel,
    output logic       keyPress,
    output logic       keyRelease,
    output logic [1:0] dbgState
);

`ifdef QA_KEY_AUTOREPEAT_EN
    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations that cannot debounce or repeat meaningfully
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("qa_key_debounce: illegal timing parameters");
    end

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             key_sync;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic             press_out_d;

    qa_sync2 u_sync (
        .sysClk   (sysClk),
        .sysReset (sysReset),
        .d        (keyIn),
        .q        (key_sync)
    );

    // Debounce counter increment, held at all-ones rather than wrapping
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // FSM state register and debounce counter
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the IDLE/HELD sample that starts a check counts as sample 0
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_sync) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!key_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!key_sync) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (key_sync) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_CHK);
    end

`ifdef QA_KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PERIOD_C = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic             rep_first_q, rep_first_d;
    logic             rep_due;
    logic             rep_fire;

    assign rep_inc = (rep_cnt_q == CNT_SAT) ? rep_cnt_q : rep_cnt_q + 1'b1;
    assign rep_due = rep_inc == (rep_first_q ? REP_DELAY_C : REP_PERIOD_C);

    // Repeat timer registers: cycles since press or last repeat, first-delay flag
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    // Repeat timer keeps running through release checks; pulses only fire while
    // the key is stably held so they never crowd a release pulse
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (state_q == ST_PRESS_CHK && state_d == ST_HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (state_q == ST_HELD || state_q == ST_RELEASE_CHK) begin
            if (rep_due) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
                rep_fire    = (state_q == ST_HELD) && key_sync;
            end else begin
                rep_cnt_d = rep_inc;
            end
        end else begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end
    end

    assign press_out_d = press_d | rep_fire;
`else
    assign press_out_d = press_d;
`endif

    // Registered outputs so level and pulses change on the same clock edge
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            keyLevel   <= 1'b0;
            keyPress   <= 1'b0;
            keyRelease <= 1'b0;
        end else begin
            keyLevel   <= level_d;
            keyPress   <= press_out_d;
            keyRelease <= release_d;
        end
    end

    assign dbgState = state_q;

endmodule

// File: tb/tb_qa_key_debounce.sv
// Directed bench for qa_key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Cycle numbers count rising edges after the stimulus
// change, sampled 1 time unit after each edge.
module tb_qa_key_debounce;

    logic       sysClk;
    logic       sysReset;
    logic       keyIn;
    logic       keyLevel;
    logic       keyPress;
    logic       keyRelease;
    logic [1:0] dbgState;

    int n_checks;
    int n_pass;
    int cyc;
    logic prev_press;
    logic prev_rel;
    logic [31:0] press_q[$];
    logic [31:0] rel_q[$];
    logic [31:0] exp_press_q[$];
    logic [31:0] exp_rel_q[$];

    qa_key_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .sysClk     (sysClk),
        .sysReset   (sysReset),
        .keyIn      (keyIn),
        .keyLevel   (keyLevel),
        .keyPress   (keyPress),
        .keyRelease (keyRelease),
        .dbgState   (dbgState)
    );

    // Clock and reset defaults
    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Start a new measurement window
    task automatic mark();
        cyc = 0;
        press_q.delete();
        rel_q.delete();
        exp_press_q.delete();
        exp_rel_q.delete();
    endtask

    // Advance one clock, log pulses, and check pulse separation
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysClk);
            #1;
            cyc++;
            if (keyPress) press_q.push_back(32'(cyc));
            if (keyRelease) rel_q.push_back(32'(cyc));
            check("pulse_sep",
                  32'((keyPress & (keyRelease | prev_rel)) | (keyRelease & prev_press)), 32'd0);
            prev_press = keyPress;
            prev_rel   = keyRelease;
        end
    endtask

    // Compare logged pulse cycles against the expected queues
    task automatic check_events(input string tag);
        check({tag, "_press_n"}, 32'(press_q.size()), 32'(exp_press_q.size()));
        for (int i = 0; i < exp_press_q.size() && i < press_q.size(); i++)
            check({tag, "_press_cyc"}, press_q[i], exp_press_q[i]);
        check({tag, "_rel_n"}, 32'(rel_q.size()), 32'(exp_rel_q.size()));
        for (int i = 0; i < exp_rel_q.size() && i < rel_q.size(); i++)
            check({tag, "_rel_cyc"}, rel_q[i], exp_rel_q[i]);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        prev_press = 1'b0;
        prev_rel   = 1'b0;
        sysReset   = 1'b1;
        keyIn      = 1'b0;
        mark();
        tick(3);
        check("rst_level", 32'(keyLevel), 32'd0);
        check("rst_press", 32'(keyPress), 32'd0);
        check("rst_release", 32'(keyRelease), 32'd0);
        check("rst_state", 32'(dbgState), 32'd0);

        // Clean press right after reset release: press and level at cycle 6
        sysReset = 1'b0;
        mark();
        keyIn = 1'b1;
        tick(5);
        check("press_level_c5", 32'(keyLevel), 32'd0);
        tick(1);
        check("press_level_c6", 32'(keyLevel), 32'd1);
        check("press_pulse_c6", 32'(keyPress), 32'd1);
        tick(1);
        check("press_pulse_c7", 32'(keyPress), 32'd0);
        tick(5);
        exp_press_q.push_back(32'd6);
        check_events("press");

        // Two-cycle release bounce: stays held, nothing emitted
        mark();
        keyIn = 1'b0;
        tick(2);
        keyIn = 1'b1;
        tick(8);
        check("bounce_level", 32'(keyLevel), 32'd1);
        check_events("bounce");

        // Clean release: keyRelease 6 cycles after the fall; a repeat due in
        // the release check window stays suppressed
        mark();
        keyIn = 1'b0;
        tick(10);
        exp_rel_q.push_back(32'd6);
        check_events("release");
        check("release_level", 32'(keyLevel), 32'd0);

        // Glitches of 1, 2 and 3 cycles separated by 5 low cycles
        mark();
        keyIn = 1'b1; tick(1);
        keyIn = 1'b0; tick(5);
        keyIn = 1'b1; tick(2);
        keyIn = 1'b0; tick(5);
        keyIn = 1'b1; tick(3);
        keyIn = 1'b0; tick(8);
        check("glitch_level", 32'(keyLevel), 32'd0);
        check_events("glitch");

        // Reset two cycles into the press check with the key held
        mark();
        keyIn = 1'b1;
        tick(5);
        check("prechk_state", 32'(dbgState), 32'd1);
        sysReset = 1'b1;
        #1;
        check("midrst_level", 32'(keyLevel), 32'd0);
        check("midrst_press", 32'(keyPress), 32'd0);
        check("midrst_state", 32'(dbgState), 32'd0);
        tick(2);
        check_events("midrst_hold");
        sysReset = 1'b0;
        mark();
        tick(10);
        exp_press_q.push_back(32'd6);
        check_events("after_rst");
        check("after_rst_level", 32'(keyLevel), 32'd1);

        // Reset while held: level drops at once, no pulses on entry or exit
        mark();
        sysReset = 1'b1;
        #1;
        check("heldrst_level", 32'(keyLevel), 32'd0);
        check("heldrst_state", 32'(dbgState), 32'd0);
        keyIn = 1'b0;
        tick(3);
        sysReset = 1'b0;
        tick(8);
        check_events("heldrst");

        // Long hold: auto-repeat pulses when the feature is built in
        mark();
        keyIn = 1'b1;
        tick(60);
        exp_press_q.push_back(32'd6);
`ifdef QA_KEY_AUTOREPEAT_EN
        exp_press_q.push_back(32'd26);
        exp_press_q.push_back(32'd34);
        exp_press_q.push_back(32'd42);
        exp_press_q.push_back(32'd50);
        exp_press_q.push_back(32'd58);
`endif
        check_events("hold");
        mark();
        keyIn = 1'b0;
        tick(10);
        exp_rel_q.push_back(32'd6);
        check_events("hold_release");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
